// File: rtl/frame_loader_if.sv
// rtl/frame_loader_if.sv - stream input and display-memory write bundle for frame_loader
interface frame_loader_if #(
    parameter int rows    = 8,
    parameter int columns = 32,
    parameter int width   = 24
);
    localparam int RW = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW = (columns > 1) ? $clog2(columns) : 1;

    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_sot;
    logic             in_eot;
    logic             frame_complete;
    logic             mem_wen;
    logic [RW-1:0]    mem_wrow;
    logic [CW-1:0]    mem_wcol;
    logic [width-1:0] mem_wdata;
    logic             mem_flip;
    logic             busy;
    logic             frame_err;

    modport slave (
        input  in_data, in_valid, in_sot, in_eot, frame_complete,
        output mem_wen, mem_wrow, mem_wcol, mem_wdata, mem_flip, busy, frame_err
    );

    modport master (
        output in_data, in_valid, in_sot, in_eot, frame_complete,
        input  mem_wen, mem_wrow, mem_wcol, mem_wdata, mem_flip, busy, frame_err
    );
endinterface

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - packs a framed byte stream into pixels and schedules the buffer flip
module frame_loader #(
    parameter int rows    = 8,
    parameter int columns = 32,
    parameter int width   = 24
) (
    input  logic           clk,
    input  logic           rst,
    frame_loader_if.slave  fl_if
);
    localparam int BPP = width / 8;
    localparam int RW  = (rows > 1) ? $clog2(rows) : 1;
    localparam int CW  = (columns > 1) ? $clog2(columns) : 1;
    localparam int BW  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam logic [RW-1:0] LAST_ROW  = RW'(rows - 1);
    localparam logic [CW-1:0] LAST_COL  = CW'(columns - 1);
    localparam logic [BW-1:0] LAST_BYTE = BW'(BPP - 1);

    typedef enum logic [1:0] {IDLE, LOAD, FLIP_WAIT} state_t;

    state_t           state_q, state_d;
    logic [width-1:0] acc_q, acc_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic             full_q, full_d;
    logic             wen_q, wen_d;
    logic [RW-1:0]    wrow_q, wrow_d;
    logic [CW-1:0]    wcol_q, wcol_d;
    logic [width-1:0] wdata_q, wdata_d;
    logic             flip_q, flip_d;
    logic             err_q, err_d;

    logic             take;
    logic             restart;
    logic [width-1:0] base_acc;
    logic [width-1:0] acc_next;
    logic [BW-1:0]    base_bcnt;
    logic [RW-1:0]    base_row;
    logic [CW-1:0]    base_col;
    logic             base_full;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bcnt_d    = bcnt_q;
        row_d     = row_q;
        col_d     = col_q;
        full_d    = full_q;
        wen_d     = 1'b0;
        wrow_d    = wrow_q;
        wcol_d    = wcol_q;
        wdata_d   = wdata_q;
        flip_d    = flip_q;
        err_d     = 1'b0;
        take      = 1'b0;
        restart   = 1'b0;

        case (state_q)
            IDLE: begin
                if (fl_if.in_valid && fl_if.in_sot) begin
                    take    = 1'b1;
                    restart = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (fl_if.in_valid) begin
                    take = 1'b1;
                    if (fl_if.in_sot) begin
                        restart = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            FLIP_WAIT: begin
                if (fl_if.in_valid || fl_if.in_sot) begin
                    err_d = 1'b1;
                end
                if (fl_if.frame_complete) begin
                    flip_d  = ~flip_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A restart byte is processed against cleared counters in the same cycle.
        base_acc  = restart ? '0 : acc_q;
        base_bcnt = restart ? '0 : bcnt_q;
        base_row  = restart ? '0 : row_q;
        base_col  = restart ? '0 : col_q;
        base_full = restart ? 1'b0 : full_q;
        acc_next  = (base_acc << 8) | width'(fl_if.in_data);

        if (take) begin
            row_d  = base_row;
            col_d  = base_col;
            full_d = base_full;
            bcnt_d = base_bcnt;
            if (base_full) begin
                err_d = 1'b1;
            end else if (base_bcnt == LAST_BYTE) begin
                acc_d   = '0;
                bcnt_d  = '0;
                wen_d   = 1'b1;
                wrow_d  = base_row;
                wcol_d  = base_col;
                wdata_d = acc_next;
                if (base_col == LAST_COL) begin
                    col_d = '0;
                    if (base_row == LAST_ROW) begin
                        full_d = 1'b1;
                    end else begin
                        row_d = base_row + RW'(1);
                    end
                end else begin
                    col_d = base_col + CW'(1);
                end
            end else begin
                acc_d  = acc_next;
                bcnt_d = base_bcnt + BW'(1);
            end
        end

        // End of frame: short or partial frames are flagged, the flip still follows.
        if (fl_if.in_eot && (state_q == LOAD || (state_q == IDLE && take))) begin
            state_d = FLIP_WAIT;
            if (!full_d || bcnt_d != '0) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            bcnt_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            full_q  <= 1'b0;
            wen_q   <= 1'b0;
            wrow_q  <= '0;
            wcol_q  <= '0;
            wdata_q <= '0;
            flip_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            bcnt_q  <= bcnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            full_q  <= full_d;
            wen_q   <= wen_d;
            wrow_q  <= wrow_d;
            wcol_q  <= wcol_d;
            wdata_q <= wdata_d;
            flip_q  <= flip_d;
            err_q   <= err_d;
        end
    end

    assign fl_if.mem_wen   = wen_q;
    assign fl_if.mem_wrow  = wrow_q;
    assign fl_if.mem_wcol  = wcol_q;
    assign fl_if.mem_wdata = wdata_q;
    assign fl_if.mem_flip  = flip_q;
    assign fl_if.busy      = (state_q != IDLE);
    assign fl_if.frame_err = err_q;
endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed and randomized checks of frame_loader against a frame-level model
module tb_frame_loader;
    localparam int R = 8;
    localparam int C = 32;
    localparam int W = 24;
    localparam int N = R * C;

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    frame_loader_if #(.rows(R), .columns(C), .width(W)) bus ();
    frame_loader #(.rows(R), .columns(C), .width(W)) dut (.clk(clk), .rst(rst), .fl_if(bus));

    int total = 0;
    int bad   = 0;
    int err_cnt = 0;
    logic [2:0]  got_row[$];
    logic [4:0]  got_col[$];
    logic [23:0] got_data[$];
    logic [2:0]  exp_row[$];
    logic [4:0]  exp_col[$];
    logic [23:0] exp_data[$];
    int exp_err;
    logic exp_flip = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_wen === 1'b1) begin
            got_row.push_back(bus.mem_wrow);
            got_col.push_back(bus.mem_wcol);
            got_data.push_back(bus.mem_wdata);
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] d, input logic v, input logic s, input logic e, input logic fc);
        bus.in_data = d; bus.in_valid = v; bus.in_sot = s; bus.in_eot = e; bus.frame_complete = fc;
        @(posedge clk); #1;
        bus.in_data = 8'h0; bus.in_valid = 1'b0; bus.in_sot = 1'b0; bus.in_eot = 1'b0;
        bus.frame_complete = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(8'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Frame-level model: each sot starts a segment; pixels are consecutive byte triples
    // addressed in row-major order, capped at N; excess bytes, restarts and short ends are errors.
    task automatic model(input bq_t b, input int restart_at);
        int starts[$];
        exp_row.delete(); exp_col.delete(); exp_data.delete();
        exp_err = 0;
        starts.push_back(0);
        if (restart_at > 0) begin
            starts.push_back(restart_at);
            exp_err++;
        end
        for (int g = 0; g < starts.size(); g++) begin
            int s = starts[g];
            int len = ((g + 1 < starts.size()) ? starts[g+1] : b.size()) - s;
            int np = (len / 3 < N) ? len / 3 : N;
            for (int i = 0; i < np; i++) begin
                exp_row.push_back(3'(i / C));
                exp_col.push_back(5'(i % C));
                exp_data.push_back({b[s+3*i], b[s+3*i+1], b[s+3*i+2]});
            end
            if (len > 3 * N) exp_err += len - 3 * N;
            if (g == starts.size() - 1 && len < 3 * N) exp_err++;
        end
    endtask

    task automatic send(input bq_t b, input int restart_at, input bit eot_last, input bit fc_eot);
        int last = b.size() - 1;
        for (int k = 0; k <= last; k++) begin
            drive(b[k], 1'b1, (k == 0 || k == restart_at), (eot_last && k == last),
                  (fc_eot && eot_last && k == last));
        end
        if (!eot_last) drive(8'h0, 1'b0, 1'b0, 1'b1, fc_eot);
    endtask

    task automatic verify(input string tag, input int wbase, input int ebase);
        int n = got_row.size() - wbase;
        int mism = 0;
        check({tag, "_nwrites"}, 64'(n), 64'(exp_row.size()));
        for (int i = 0; i < n && i < exp_row.size(); i++) begin
            if (got_row[wbase+i] !== exp_row[i] || got_col[wbase+i] !== exp_col[i] ||
                got_data[wbase+i] !== exp_data[i]) mism++;
        end
        check({tag, "_write_content"}, 64'(mism), 64'd0);
        check({tag, "_frame_err"}, 64'(err_cnt - ebase), 64'(exp_err));
        check({tag, "_flip_held"}, 64'(bus.mem_flip), 64'(exp_flip));
        check({tag, "_busy_wait"}, 64'(bus.busy), 64'd1);
    endtask

    task automatic do_flip(input string tag);
        drive(8'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp_flip = ~exp_flip;
        idle(1);
        check({tag, "_flip"}, 64'(bus.mem_flip), 64'(exp_flip));
        check({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        bq_t b;
        int wb, eb;
        bus.in_data = 8'h0; bus.in_valid = 1'b0; bus.in_sot = 1'b0; bus.in_eot = 1'b0;
        bus.frame_complete = 1'b0;
        #12;
        check("rst_wen", 64'(bus.mem_wen), 64'd0);
        check("rst_wrow", 64'(bus.mem_wrow), 64'd0);
        check("rst_wcol", 64'(bus.mem_wcol), 64'd0);
        check("rst_wdata", 64'(bus.mem_wdata), 64'd0);
        check("rst_flip", 64'(bus.mem_flip), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_err", 64'(bus.frame_err), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        idle(2);

        // Full ramp frame, eot on its own cycle, flip 10 clocks later.
        b.delete();
        for (int k = 0; k < 3 * N; k++) b.push_back(8'(k));
        wb = got_row.size(); eb = err_cnt;
        model(b, -1);
        send(b, -1, 1'b0, 1'b0);
        idle(9);
        verify("full", wb, eb);
        check("full_first_data", 64'(got_data[wb]), 64'h000102);
        check("full_last_addr", 64'({got_row[wb+N-1], got_col[wb+N-1]}), 64'({3'd7, 5'd31}));
        do_flip("full");

        // Random full frame with valid+eot on the last byte and frame_complete in that cycle,
        // then a long window without frame_complete where stray bytes are dropped.
        b.delete();
        for (int k = 0; k < 3 * N; k++) b.push_back(8'($urandom));
        wb = got_row.size(); eb = err_cnt;
        model(b, -1);
        send(b, -1, 1'b1, 1'b1);
        for (int t = 0; t < 500; t++) begin
            if (t % 100 == 50) drive(8'($urandom), 1'b1, (t == 250), 1'b0, 1'b0);
            else idle(1);
        end
        exp_err += 5;
        verify("gate", wb, eb);
        do_flip("gate");

        // Short frame with a trailing partial pixel.
        b.delete();
        for (int k = 0; k < 7; k++) b.push_back(8'($urandom));
        wb = got_row.size(); eb = err_cnt;
        model(b, -1);
        send(b, -1, 1'b0, 1'b0);
        idle(3);
        verify("short", wb, eb);
        do_flip("short");

        // Overlong frame: three bytes past the last pixel.
        b.delete();
        for (int k = 0; k < 3 * N + 3; k++) b.push_back(8'($urandom));
        wb = got_row.size(); eb = err_cnt;
        model(b, -1);
        send(b, -1, 1'b0, 1'b0);
        idle(3);
        verify("long", wb, eb);
        do_flip("long");

        // Restart at byte 100, then a short tail.
        b.delete();
        for (int k = 0; k < 109; k++) b.push_back(8'($urandom));
        wb = got_row.size(); eb = err_cnt;
        model(b, 100);
        send(b, 100, 1'b0, 1'b0);
        idle(3);
        verify("restart", wb, eb);
        check("restart_addr", 64'({got_row[wb+33], got_col[wb+33]}), 64'd0);
        do_flip("restart");

        // Asynchronous reset mid-LOAD, away from the clock edge.
        drive(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 49; k++) drive(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
        check("arst_busy_before", 64'(bus.busy), 64'd1);
        #2 rst = 1'b0;
        #1;
        exp_flip = 1'b0;
        check("arst_flip", 64'(bus.mem_flip), 64'd0);
        check("arst_busy", 64'(bus.busy), 64'd0);
        check("arst_wen", 64'(bus.mem_wen), 64'd0);
        check("arst_wdata", 64'(bus.mem_wdata), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);
        b.delete();
        for (int k = 0; k < 12; k++) b.push_back(8'($urandom));
        wb = got_row.size(); eb = err_cnt;
        model(b, -1);
        send(b, -1, 1'b0, 1'b0);
        idle(3);
        verify("post_rst", wb, eb);
        do_flip("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
